// File: rtl/m_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// m_seg_scan_ctrl
//
// Multiplexed 8-digit 7-segment scan controller. A 32-bit word is loaded into
// a shadow register and moved to the displayed register only when the scan
// wraps from the last digit back to digit 0, so a frame never shows a mix of
// old and new nibbles.
//
// Parameters
//   CLK_DIV    : clk cycles per digit slot (1 .. 2**20)
//   NUM_DIGITS : number of digits, fixed at 8
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   value     in  32  word to display
//   load      in   1  one-cycle strobe, captures value into the shadow register
//   hex_num   out  4  nibble of the digit currently enabled
//   digit_an  out  8  active-low digit enables (one-hot-low)
//   pending   out  1  a loaded word is waiting for the next frame boundary
//   frame_upd out  1  one-cycle pulse when a new word starts being displayed
//
// Configuration
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits (other than
//                           digit 0) are switched off; scan timing unchanged.
// ---------------------------------------------------------------------------
module m_seg_scan_ctrl #(
    parameter int CLK_DIV    = 50000,
    parameter int NUM_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           value,
    input  logic                  load,
    output logic [3:0]            hex_num,
    output logic [NUM_DIGITS-1:0] digit_an,
    output logic                  pending,
    output logic                  frame_upd
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]      div_cnt_q,   div_cnt_d;
    logic [2:0]            digit_idx_q, digit_idx_d;
    logic [31:0]           shadow_q,    shadow_d;
    logic [31:0]           disp_q,      disp_d;
    logic                  pending_q,   pending_d;
    logic                  frame_upd_q, frame_upd_d;

    logic                  tick;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] an_onehot;

    // Next-state logic.
    // NOTE: every signal gets a default at the top of the block so no path can
    // leave it unassigned, which is what would otherwise infer a latch.
    always_comb begin
        div_cnt_d   = div_cnt_q;
        digit_idx_d = digit_idx_q;
        shadow_d    = shadow_q;
        disp_d      = disp_q;
        pending_d   = pending_q;
        frame_upd_d = 1'b0;

        // With CLK_DIV == 1 the counter is stuck at 0 == DIV_LAST, so tick is
        // high every cycle.
        tick      = (div_cnt_q == DIV_LAST);
        frame_end = tick && (digit_idx_q == 3'd7);

        if (tick) begin
            div_cnt_d   = '0;
            digit_idx_d = digit_idx_q + 3'd1;
        end else begin
            div_cnt_d   = div_cnt_q + 1'b1;
        end

        // Transfer happens on the same edge that moves the scan to digit 0,
        // so the new word is shown from the first digit of the next frame.
        if (frame_end && pending_q) begin
            disp_d      = shadow_q;
            pending_d   = 1'b0;
            frame_upd_d = 1'b1;
        end

        // A load in the transfer cycle is ordered after the transfer: the old
        // shadow goes to the display and the new word stays pending.
        if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            digit_idx_q <= 3'd0;
            shadow_q    <= 32'h0;
            disp_q      <= 32'h0;
            pending_q   <= 1'b0;
            frame_upd_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            shadow_q    <= shadow_d;
            disp_q      <= disp_d;
            pending_q   <= pending_d;
            frame_upd_q <= frame_upd_d;
        end
    end

    // Outputs are decoded from registered state only; value/load never reach
    // them combinationally.
    always_comb begin
        hex_num   = disp_q[{digit_idx_q, 2'b00} +: 4];
        an_onehot = ~(NUM_DIGITS'(1) << digit_idx_q);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;

    // Digit i (i > 0) is blanked when it and every more significant nibble
    // are zero. Digit 0 always stays lit so a zero word still shows "0".
    always_comb begin
        blank = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            blank[i] = ((disp_q >> (4 * i)) == 32'h0);
        end
        digit_an = an_onehot | blank;
    end
`else
    always_comb begin
        digit_an = an_onehot;
    end
`endif

    assign pending   = pending_q;
    assign frame_upd = frame_upd_q;

endmodule

// File: doc/m_seg_scan_ctrl.md
M_SEG_SCAN_CTRL -- requirements
Module: m_seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000, clk cycles per digit slot (legal range 1..2^20).
REQ-002 Parameter NUM_DIGITS, fixed 8; digit i displays nibble value[4*i+3:4*i].
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 value  input  32  word to display (e.g. PC or register contents).
REQ-006 load  input  1  one-cycle strobe; captures value into shadow register.
REQ-007 hex_num  output  4  nibble of current digit; feeds the 7-segment decoder's hex_num input.
REQ-008 digit_an  output  8  active-low digit enables, one-hot-low.
REQ-009 pending  output  1  high while a loaded value awaits transfer to the display.
REQ-010 frame_upd  output  1  one-cycle pulse when a new value starts being displayed.

Function
REQ-011 div_cnt SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be asserted in the cycle div_cnt==CLK_DIV-1; with CLK_DIV=1, tick SHALL be high every cycle.
REQ-012 digit_idx (3 bits) SHALL increment on each tick, wrapping 7->0.
REQ-013 hex_num SHALL equal disp_reg[4*digit_idx+3:4*digit_idx], and digit_an SHALL equal ~(1<<digit_idx), both from registered state with no combinational path from value or load.
REQ-014 A new digit SHALL appear on hex_num/digit_an in the cycle after the tick that advances digit_idx.
REQ-015 On load=1, shadow SHALL capture value and pending SHALL set at the next edge; multiple loads before transfer: last value wins.
REQ-016 Frame boundary = tick with digit_idx==7; at it, if pending=1, disp_reg SHALL take shadow, pending SHALL clear and frame_upd SHALL pulse high for exactly the following cycle.
REQ-017 Frame boundary with pending=0 SHALL leave disp_reg unchanged and SHALL NOT pulse frame_upd.
REQ-018 load coincident with a transferring frame boundary: disp_reg SHALL take the old shadow, shadow SHALL take the new value, pending SHALL remain 1.
REQ-019 disp_reg SHALL change only at frame boundaries (no tearing within a scan frame).

Reset
REQ-020 rst_n low SHALL immediately, without clk, force div_cnt=0, digit_idx=0, shadow=0, disp_reg=0, pending=0, frame_upd=0, hence hex_num=4'h0, digit_an=8'hFE.
REQ-021 Reset asserted mid-frame or with pending=1 SHALL discard the pending value; scanning restarts at digit 0 on the first edge after rst_n rises.

Configuration
REQ-022 Macro LEADING_ZERO_BLANK_EN defined: a digit i>0 whose nibble and all higher nibbles of disp_reg are zero SHALL have its digit_an bit forced to 1 (off); digit 0 is never blanked; scan timing unchanged.
REQ-023 Macro LEADING_ZERO_BLANK_EN undefined: all eight digits SHALL be enabled in turn per REQ-013, blanking logic absent.

Verification (CLK_DIV=4 unless noted)
REQ-024 Reset release, disp_reg=0 -> digit_an steps FE,FD,FB,...,7F,FE every 4 cycles; hex_num=0 throughout.
REQ-025 load value=32'h1234_ABCD mid-frame -> pending=1 next cycle; disp_reg unchanged until digit_idx 7 tick; frame_upd one-cycle pulse; next frame hex_num sequence D,C,B,A,4,3,2,1.
REQ-026 load 32'h1111_1111 then 32'h2222_2222 within one frame -> only 2222_2222 displayed; single frame_upd pulse.
REQ-027 load 32'hFFFF_FFFF in the boundary cycle while shadow=32'h5 pending -> next frame shows 5, pending stays 1, following frame shows FFFF_FFFF with second frame_upd.
REQ-028 rst_n pulsed low mid-frame with pending=1 -> outputs to reset values asynchronously; pending=0; no frame_upd afterwards.
REQ-029 LEADING_ZERO_BLANK_EN defined, disp_reg=32'h0000_00A0 -> digit_an low only for digits 0,1; disp_reg=0 -> only digit 0 enabled; CLK_DIV=1 -> digit changes every cycle.
